// File: rtl/game_round_timer_pkg.sv
// rtl/game_round_timer_pkg.sv - shared game-state encodings and BCD/ASCII helpers for the round timer
package game_round_timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_GAME  = 2'd2;
  localparam logic [1:0] ST_SCORE = 2'd3;

  localparam logic [6:0] ASCII_ZERO = 7'h30;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_EXPIRED
  } timer_state_t;

  // Two-digit BCD value packed as {tens, units}.
  function automatic logic [7:0] to_bcd(input int unsigned n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic int unsigned bcd_to_int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [6:0] to_ascii(input logic [3:0] d);
    return {ASCII_ZERO[6:4], d};
  endfunction

endpackage

// File: rtl/game_round_timer_if.sv
// rtl/game_round_timer_if.sv - control inputs and display/status outputs of the round timer
interface game_round_timer_if;
  logic [1:0] state;
  logic       freeze;
  logic       time_up;
  logic       running;
  logic       warn;
  logic [6:0] ascii_1;
  logic [6:0] ascii_0;

  modport master (
    output state, freeze,
    input  time_up, running, warn, ascii_1, ascii_0
  );

  modport slave (
    input  state, freeze,
    output time_up, running, warn, ascii_1, ascii_0
  );
endinterface

// File: rtl/game_round_timer_sec_tick_gen.sv
// rtl/game_round_timer_sec_tick_gen.sv - one-second prescaler producing a single-cycle tick
module sec_tick_gen #(
  parameter int CLK_FREQ = 75_000_000
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_FREQ - 1);

  logic [PW-1:0] count;

  // Clear wins over a coincident terminal count so a reload never also decrements.
  assign tick = en && !clr && (count == TC);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/game_round_timer.sv
// rtl/game_round_timer.sv - GAME-state round countdown with BCD seconds, time_up pulse and ASCII digits
module game_round_timer
  import game_round_timer_pkg::*;
#(
  parameter int CLK_FREQ  = 75_000_000,
  parameter int ROUND_SEC = 30,
  parameter int WARN_SEC  = 5
) (
  input logic pclk,
  input logic rst,
  game_round_timer_if.slave bus
);

  localparam logic [7:0] ROUND_BCD = to_bcd(ROUND_SEC);

  logic [1:0]   state_q;
  timer_state_t fsm;
  logic [7:0]   secs;
  logic [7:0]   secs_d;
  logic         in_game;
  logic         entry;
  logic         tick_en;
  logic         tick;
  logic         warn_d;
  logic         time_up_q;
  logic         running_q;
  logic         warn_q;
  logic [6:0]   ascii_1_q;
  logic [6:0]   ascii_0_q;

  assign in_game = (bus.state == ST_GAME);
  assign entry   = in_game && (state_q != ST_GAME);
  // Ticks only while actually counting; leaving GAME suppresses a coincident final tick.
  assign tick_en = (fsm == T_RUN) && in_game && !bus.freeze;

  sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .pclk (pclk),
    .rst  (rst),
    .clr  (entry),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    secs_d = secs;
    if (entry) begin
      secs_d = ROUND_BCD;
    end else if (tick && secs != 8'h00) begin
      secs_d = bcd_dec(secs);
    end
  end

  assign warn_d = (secs != 8'h00) && (bcd_to_int(secs) <= WARN_SEC);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      fsm       <= T_IDLE;
      secs      <= ROUND_BCD;
      time_up_q <= 1'b0;
      running_q <= 1'b0;
      warn_q    <= 1'b0;
      ascii_1_q <= to_ascii(ROUND_BCD[7:4]);
      ascii_0_q <= to_ascii(ROUND_BCD[3:0]);
    end else begin
      state_q   <= bus.state;
      secs      <= secs_d;
      ascii_1_q <= to_ascii(secs_d[7:4]);
      ascii_0_q <= to_ascii(secs_d[3:0]);
      warn_q    <= warn_d;
      time_up_q <= 1'b0;
      case (fsm)
        T_IDLE: begin
          if (entry) begin
            fsm       <= T_RUN;
            running_q <= 1'b1;
          end
        end
        T_RUN: begin
          if (!in_game) begin
            fsm       <= T_IDLE;
            running_q <= 1'b0;
          end else if (tick && secs_d == 8'h00) begin
            fsm       <= T_EXPIRED;
            running_q <= 1'b0;
            time_up_q <= 1'b1;
          end
        end
        T_EXPIRED: begin
          if (!in_game) fsm <= T_IDLE;
        end
        default: begin
          fsm       <= T_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.time_up = time_up_q;
  assign bus.running = running_q;
  assign bus.warn    = warn_q;
  assign bus.ascii_1 = ascii_1_q;
  assign bus.ascii_0 = ascii_0_q;

endmodule

// File: tb/tb_game_round_timer.sv
// tb/tb_game_round_timer.sv - directed self-checking bench for game_round_timer
module tb_game_round_timer;
  import game_round_timer_pkg::*;

  logic pclk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail = 0;

  game_round_timer_if bus ();

  game_round_timer #(
    .CLK_FREQ (10),
    .ROUND_SEC(12),
    .WARN_SEC (5)
  ) dut (
    .pclk(pclk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] tens, input logic [6:0] units);
    check({tag, "_tens"}, {1'b0, bus.ascii_1}, {1'b0, tens});
    check({tag, "_units"}, {1'b0, bus.ascii_0}, {1'b0, units});
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.state  = ST_IDLE;
    bus.freeze = 1'b0;
    cyc(3);

    // Reset values
    check("rst_time_up", {7'd0, bus.time_up}, 8'd0);
    check("rst_running", {7'd0, bus.running}, 8'd0);
    check("rst_warn", {7'd0, bus.warn}, 8'd0);
    check_digits("rst", 7'h31, 7'h32);

    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      check("idle_running", {7'd0, bus.running}, 8'd0);
    end

    // Full round: entry edge is E0
    bus.state = ST_GAME;
    cyc(1);
    check("entry_running", {7'd0, bus.running}, 8'd1);
    check_digits("e0", 7'h31, 7'h32);
    cyc(9);
    check_digits("e9", 7'h31, 7'h32);
    cyc(1);
    check_digits("e10", 7'h31, 7'h31);
    cyc(9);
    check_digits("e19", 7'h31, 7'h31);
    cyc(1);
    check_digits("e20", 7'h31, 7'h30);
    cyc(9);
    check_digits("e29", 7'h31, 7'h30);
    cyc(1);
    check_digits("borrow", 7'h30, 7'h39);
    cyc(40);
    check_digits("e70", 7'h30, 7'h35);
    check("warn_lag", {7'd0, bus.warn}, 8'd0);
    cyc(1);
    check("warn_on", {7'd0, bus.warn}, 8'd1);
    cyc(48);
    check_digits("e119", 7'h30, 7'h31);
    check("time_up_early", {7'd0, bus.time_up}, 8'd0);
    check("running_e119", {7'd0, bus.running}, 8'd1);
    cyc(1);
    check_digits("e120", 7'h30, 7'h30);
    check("time_up_pulse", {7'd0, bus.time_up}, 8'd1);
    check("warn_at_01_lag", {7'd0, bus.warn}, 8'd1);
    check("running_expired", {7'd0, bus.running}, 8'd0);
    cyc(1);
    check("time_up_single", {7'd0, bus.time_up}, 8'd0);
    check("warn_off_00", {7'd0, bus.warn}, 8'd0);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("expired_no_pulse", {7'd0, bus.time_up}, 8'd0);
      check("expired_hold_units", {1'b0, bus.ascii_0}, 8'h30);
      check("expired_hold_tens", {1'b0, bus.ascii_1}, 8'h30);
    end

    // Freeze round: entry edge F0, freeze for edges F26..F60
    bus.state = ST_IDLE;
    cyc(2);
    bus.state = ST_GAME;
    cyc(1);
    check_digits("f0", 7'h31, 7'h32);
    cyc(25);
    check_digits("f25", 7'h31, 7'h30);
    bus.freeze = 1'b1;
    cyc(35);
    check_digits("frozen", 7'h31, 7'h30);
    bus.freeze = 1'b0;
    cyc(4);
    check_digits("f64", 7'h31, 7'h30);
    cyc(1);
    check_digits("f65", 7'h30, 7'h39);
    cyc(89);
    check_digits("f154", 7'h30, 7'h31);
    check("freeze_time_up_early", {7'd0, bus.time_up}, 8'd0);
    cyc(1);
    check("freeze_time_up_late", {7'd0, bus.time_up}, 8'd1);
    check_digits("f155", 7'h30, 7'h30);

    // Abort at 04 and reload
    bus.state = ST_IDLE;
    cyc(2);
    bus.state = ST_GAME;
    cyc(1);
    check_digits("a0", 7'h31, 7'h32);
    cyc(80);
    check_digits("a80", 7'h30, 7'h34);
    bus.state = ST_SCORE;
    cyc(1);
    check("abort_running", {7'd0, bus.running}, 8'd0);
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      check("abort_no_time_up", {7'd0, bus.time_up}, 8'd0);
      check("abort_hold_units", {1'b0, bus.ascii_0}, 8'h34);
    end
    check_digits("abort_hold", 7'h30, 7'h34);
    bus.state = ST_IDLE;
    cyc(2);
    bus.state = ST_GAME;
    cyc(1);
    check_digits("reload", 7'h31, 7'h32);
    check("reload_running", {7'd0, bus.running}, 8'd1);

    // Async reset mid-round
    cyc(35);
    check_digits("r35", 7'h30, 7'h39);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_running", {7'd0, bus.running}, 8'd0);
    check("async_time_up", {7'd0, bus.time_up}, 8'd0);
    check_digits("async", 7'h31, 7'h32);
    cyc(3);
    check("async_hold_running", {7'd0, bus.running}, 8'd0);
    check_digits("async_hold", 7'h31, 7'h32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
